chacha_keystream_xor: RTL
=========================

# chacha_keystream_xor

Drives the ChaCha20 round core (`PerformQround`) from the front and consumes its result from the back. It builds the 4x4 initial state from key, nonce and block counter, and launches each block with `setRounds`. On `blockready` it performs the feed-forward addition, then XORs the 16 resulting keystream words with a 32-bit plaintext stream under valid/ready handshakes. It sits between the AEAD controller and the round core, and requests successive blocks with an incremented counter until the message ends.

## Interface
- No parameters.
- `clk`  in  1  — system clock.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — one-cycle pulse; accepted only in IDLE; latches `key`, `nonce` and `init_counter`.
- `key`  in  256  — `key[32*i+:32]` is key word i (already little-endian assembled).
- `nonce`  in  96  — `nonce[32*j+:32]` is nonce word j.
- `init_counter`  in  32  — block counter for the first block.
- `chachamatrixIN`  out  word_t [3:0][3:0]  — state to the core.
- `setRounds`  out  1  — load strobe to the core.
- `chachamatrixOUT`  in  word_t [3:0][3:0]  — post-round working state from the core, without feed-forward.
- `blockready`  in  1  — core result valid.
- `pt_valid` / `pt_ready` / `pt_data[31:0]` / `pt_last`  — plaintext input stream.
- `ct_valid` / `ct_ready` / `ct_data[31:0]` / `ct_last`  — ciphertext output stream.
- `busy`  out  1  — high whenever the FSM is not in IDLE.
- `ctr_overflow`  out  1  — sticky error flag; cleared by `rst` or by an accepted `start`.

## Operation
- **State layout:** linear word n maps to matrix element [3-n/4][3-n%4].
  - Words 0-3: 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
  - Words 4-11: key words 0-7.
  - Word 12: counter.
  - Words 13-15: nonce words 0-2.
- **FSM states:** IDLE, LOAD, WAIT, ADD, STREAM, DRAIN, ERR.
- **IDLE -> LOAD:** on `start`.
- **LOAD:** `setRounds`=1 for exactly one cycle, with `chachamatrixIN` valid. Go to WAIT.
- **WAIT:** `chachamatrixIN` is held stable. On the first cycle with `blockready`=1, capture `chachamatrixOUT` and go to ADD.
- **ADD:** one cycle. `ks[n] = out[n] + init[n]` mod 2^32 for all 16 words. Word index k=0. Go to STREAM.
- **STREAM:**
  - `pt_ready` = 1 iff the output register is empty or `ct_ready`=1.
  - On a `pt_valid`&`pt_ready` handshake: `ct_data` <= `pt_data` ^ `ks[k]`, `ct_last` <= `pt_last`, `ct_valid` <= 1, and k increments.
- **Accepted beat with `pt_last`=1:** go to DRAIN. The remaining keystream is discarded.
- **k wraps 15->0 without `pt_last`:**
  - If counter == 0xFFFFFFFF: go to ERR.
  - Otherwise: counter+1, go to LOAD. `pt_ready`=0 outside STREAM.
- **DRAIN:** wait until the output register is empty or its beat is accepted, then go to IDLE.
- **ERR:**
  - `ctr_overflow`=1 and `pt_ready`=0.
  - Any pending ct beat still drains normally.
  - Exit only via `rst`, or via `start` once the ct register is empty (go to LOAD).
- **Ignored inputs:** `start` in any state other than IDLE or ERR is ignored. `blockready` outside WAIT is ignored.
- **Output register:** `ct_valid` is held until `ct_ready`; `ct_data` and `ct_last` stay stable while `ct_valid`=1 and `ct_ready`=0.

## Timing
- **Reset values:** all outputs 0: `chachamatrixIN` all-zero, `setRounds`, `ct_valid`, `ct_data`, `ct_last`, `pt_ready`, `busy`, `ctr_overflow`. FSM goes to IDLE and counter to 0.
- **Reset mid-block:** abandons the core transaction. `setRounds` stays 0, so the core result is ignored.
- **`start` to `setRounds`:** `start` sampled at edge t; `setRounds`=1 during cycle t+1.
- **`blockready` to `pt_ready`:** `blockready` sampled at edge t; ADD during cycle t+1; `pt_ready` may be 1 from cycle t+2.
- **Plaintext to ciphertext:** 1-cycle latency. A pt beat accepted at edge t gives `ct_valid`=1 after edge t.
- **Throughput:** one word per cycle in STREAM when `ct_ready`=1.
- **Per-block overhead:** LOAD + WAIT (core latency) + ADD.
- **Simultaneous events:** the 16th handshake and the counter increment happen on the same edge, and LOAD follows the next cycle. The `pt_last` check takes priority over the k-wrap/counter logic.

## Test plan
- **RFC 7539 §2.3.2 vector:** key words 0x03020100..0x1f1e1d1c, nonce words 0x09000000/0x4a000000/0x00000000, counter 1, 16 zero pt words with `pt_last` on word 15 -> ct word 0 = 0xe4e7f110, word 1 = 0x15593bd1, word 15 = 0x4e3c50a2; `ct_last` on word 15; return to IDLE.
- **Two-block message:** same key/nonce, counter 1, 20 pt words -> exactly two `setRounds` pulses; the second carries counter 2 at [0][3]; ct words 16-19 equal block-2 keystream ^ pt.
- **Backpressure:** hold `ct_ready`=0 for 5 cycles mid-block -> `pt_ready`=0, and `ct_data` stable for those cycles; no word lost or duplicated.
- **Counter wrap:** `init_counter`=0xFFFFFFFF, 17 pt words -> 16 ct words emitted, then `ctr_overflow`=1 and `pt_ready`=0; a new `start` clears the flag.
- **Early end and reset:** `pt_last` on word 3 -> no further `setRounds`, `busy` drops after `ct_last` is accepted. Asserting `rst` during WAIT -> all outputs 0 the next cycle, and a later `blockready` is ignored.

Source files
------------

// File: rtl/chacha_keystream_xor_if.sv
// Valid/ready word stream carrying 32-bit data with an end-of-message marker.
interface chacha_keystream_xor_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/chacha_keystream_xor.sv
// ChaCha20 block sequencer: builds core input states, adds the feed-forward and
// XORs the resulting keystream onto a plaintext word stream, block after block.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | setRounds strobe, core input valid
// WAIT   | core running, input held, wait for blockready
// ADD    | feed-forward addition into keystream buffer
// STREAM | XOR keystream words onto plaintext beats
// DRAIN  | message ended, flush the output register
// ERR    | block counter exhausted, sticky overflow
module chacha_keystream_xor (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [255:0]           key_i,
    input  logic [95:0]            nonce_i,
    input  logic [31:0]            init_counter_i,
    output logic [3:0][3:0][31:0]  chachamatrixIN_o,
    output logic                   setRounds_o,
    input  logic [3:0][3:0][31:0]  chachamatrixOUT_i,
    input  logic                   blockready_i,
    chacha_keystream_xor_if.slave  pt,
    chacha_keystream_xor_if.master ct,
    output logic                   busy_o,
    output logic                   ctr_overflow_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_ADD, S_STREAM, S_DRAIN, S_ERR
    } state_t;

    state_t                 state_q;
    logic [3:0]             k_q;
    logic [31:0]            counter_q;
    logic [255:0]           key_q;
    logic [95:0]            nonce_q;
    logic [3:0][3:0][31:0]  init_q;
    logic [15:0][31:0]      ks_q;
    logic                   set_rounds_q;
    logic                   ct_valid_q;
    logic [31:0]            ct_data_q;
    logic                   ct_last_q;
    logic                   ctr_overflow_q;

    logic                   pt_ready;
    logic                   pt_hs;
    logic [31:0]            ct_data_d;
    logic [31:0]            counter_d;

    // Linear word n lives at matrix element [3-n/4][3-n%4].
    function automatic logic [3:0][3:0][31:0] build_state(input logic [255:0] key,
                                                          input logic [95:0]  nonce,
                                                          input logic [31:0]  ctr);
        logic [15:0][31:0] w;
        logic [3:0][3:0][31:0] m;
        w[0] = 32'h61707865;
        w[1] = 32'h3320646e;
        w[2] = 32'h79622d32;
        w[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) w[4+i] = key[32*i +: 32];
        w[12] = ctr;
        for (int j = 0; j < 3; j++) w[13+j] = nonce[32*j +: 32];
        for (int n = 0; n < 16; n++) m[3-n/4][3-n%4] = w[n];
        return m;
    endfunction

    assign pt_ready  = (state_q == S_STREAM) && (!ct_valid_q || ct.ready);
    assign pt_hs     = pt.valid && pt_ready;
    assign ct_data_d = pt.data ^ ks_q[k_q];
    assign counter_d = counter_q + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            counter_q      <= '0;
            key_q          <= '0;
            nonce_q        <= '0;
            init_q         <= '0;
            ks_q           <= '0;
            set_rounds_q   <= 1'b0;
            ct_valid_q     <= 1'b0;
            ct_data_q      <= '0;
            ct_last_q      <= 1'b0;
            ctr_overflow_q <= 1'b0;
        end else begin
            set_rounds_q <= 1'b0;
            if (pt_hs) begin
                ct_valid_q <= 1'b1;
                ct_data_q  <= ct_data_d;
                ct_last_q  <= pt.last;
            end else if (ct.ready) begin
                ct_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE, S_ERR: begin
                    // Restart from ERR only once the pending ct beat is gone.
                    if (start_i && (state_q == S_IDLE || !ct_valid_q)) begin
                        key_q          <= key_i;
                        nonce_q        <= nonce_i;
                        counter_q      <= init_counter_i;
                        init_q         <= build_state(key_i, nonce_i, init_counter_i);
                        ctr_overflow_q <= 1'b0;
                        set_rounds_q   <= 1'b1;
                        state_q        <= S_LOAD;
                    end
                end
                S_LOAD: state_q <= S_WAIT;
                S_WAIT: begin
                    if (blockready_i) begin
                        for (int n = 0; n < 16; n++) ks_q[n] <= chachamatrixOUT_i[3-n/4][3-n%4];
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    for (int n = 0; n < 16; n++) ks_q[n] <= ks_q[n] + init_q[3-n/4][3-n%4];
                    k_q     <= 4'd0;
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (pt_hs) begin
                        k_q <= k_q + 4'd1;
                        if (pt.last) begin
                            state_q <= S_DRAIN;
                        end else if (k_q == 4'd15) begin
                            if (counter_q == 32'hFFFF_FFFF) begin
                                ctr_overflow_q <= 1'b1;
                                state_q        <= S_ERR;
                            end else begin
                                counter_q    <= counter_d;
                                init_q       <= build_state(key_q, nonce_q, counter_d);
                                set_rounds_q <= 1'b1;
                                state_q      <= S_LOAD;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!ct_valid_q || ct.ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign chachamatrixIN_o = init_q;
    assign setRounds_o      = set_rounds_q;
    assign pt.ready         = pt_ready;
    assign ct.valid         = ct_valid_q;
    assign ct.data          = ct_data_q;
    assign ct.last          = ct_last_q;
    assign busy_o           = (state_q != S_IDLE);
    assign ctr_overflow_o   = ctr_overflow_q;

endmodule
